// File: rtl/management_tx_fifo_pkg.sv
// Shared definitions for the management TX FIFO: register map, send FSM states,
// frame length limits and small length/byte-lane helpers.
package management_tx_fifo_pkg;

    typedef enum logic [9:0] {
        TX_DATA_BASE = 10'h000,
        TX_COUNT     = 10'h3FD,
        TX_COMMIT    = 10'h3FE,
        TX_FREE      = 10'h3FF
    } reg_addr_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_SEND,
        S_GAP
    } send_state_e;

    localparam int DEFAULT_MAX_LEN = 1514;
    localparam int LEN_W           = 11;

    function automatic logic [LEN_W-1:0] len_to_words(input logic [LEN_W-1:0] len);
        return LEN_W'(({1'b0, len} + 12'd3) >> 2);
    endfunction

    // Keeps only the leading valid bytes of a big-endian packed word.
    function automatic logic [31:0] byte_mask(input logic [2:0] nbytes);
        case (nbytes)
            3'd1:    return 32'hFF00_0000;
            3'd2:    return 32'hFFFF_0000;
            3'd3:    return 32'hFFFF_FF00;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/management_tx_fifo_tx_packet_buffer.sv
// Single-clock 32-bit word FIFO with a committed write pointer (commit/rollback),
// a release pointer that frees space only once a whole frame is done, and registered read.
module tx_packet_buffer #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     wr_en_i,
    input  logic [31:0]              wr_data_i,
    input  logic                     commit_i,
    input  logic                     rollback_i,
    input  logic                     rd_en_i,
    input  logic [31:0]              rd_mask_i,
    input  logic                     release_i,
    output logic [31:0]              rd_data_o,
    output logic [$clog2(DEPTH):0]   used_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] cm_ptr_q, cm_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] rel_ptr_q, rel_ptr_d;
    logic [31:0] rd_data_q;
    logic        wr_ok;

    assign used_o    = wr_ptr_q - rel_ptr_q;
    assign full_o    = used_o[AW];
    assign wr_ok     = wr_en_i && !full_o && !rollback_i && !flush_i;
    assign rd_data_o = rd_data_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        cm_ptr_d  = cm_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rel_ptr_d = rel_ptr_q;
        if (flush_i) begin
            wr_ptr_d  = '0;
            cm_ptr_d  = '0;
            rd_ptr_d  = '0;
            rel_ptr_d = '0;
        end else begin
            if (rollback_i) begin
                wr_ptr_d = cm_ptr_q;
            end else if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (commit_i) begin
                cm_ptr_d = wr_ptr_d;
            end
            if (rd_en_i) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (release_i) begin
                rel_ptr_d = rd_ptr_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            cm_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rel_ptr_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            cm_ptr_q  <= cm_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rel_ptr_q <= rel_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    // Output register reads as zero whenever no word is being fetched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en_i && !flush_i) begin
            rd_data_q <= mem[rd_ptr_q[AW-1:0]] & rd_mask_i;
        end else begin
            rd_data_q <= '0;
        end
    end

endmodule

// File: rtl/management_tx_fifo.sv
// Management-to-MAC transmit buffer: APB halfword writes, length commit, frame replay.
// Define MGMT_TX_FRAME_COUNTER_EN to add the read-only TX_COUNT register at 0xFF4.
module management_tx_fifo
    import management_tx_fifo_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int HDR_DEPTH = 32,
    parameter int MAX_LEN   = DEFAULT_MAX_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [11:0] paddr,
    input  logic [15:0] pwdata,
    output logic        pready,
    output logic [15:0] prdata,
    output logic        pslverr,
    input  logic        link_up,
    input  logic        tx_ready,
    output logic        tx_start,
    output logic        tx_data_valid,
    output logic [2:0]  tx_bytes_valid,
    output logic [31:0] tx_data,
    output logic        tx_frame_pending
);

    localparam int AW  = $clog2(DEPTH);
    localparam int HAW = $clog2(HDR_DEPTH);

    logic              pready_q, pready_d, pslverr_q, pslverr_d;
    logic [15:0]       prdata_q, prdata_d;
    logic              staged_q, staged_d, poison_q, poison_d;
    logic [15:0]       stage_hi_q, stage_hi_d;
    logic [AW:0]       words_q, words_d;
    send_state_e       state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              tx_start_q, tx_start_d, tx_dv_q, tx_dv_d;
    logic [2:0]        tx_bv_q, tx_bv_d;

    logic              access, is_free, is_commit, is_count, unused_addr_bits;
    logic [15:0]       count_value, free_sat;
    logic [31:0]       free_words;
    logic [LEN_W-1:0]  commit_len, issue_bytes, issue_rem;
    logic [2:0]        issue_bv;
    logic              reject;

    logic              buf_wr, buf_commit, buf_rollback, buf_rd, buf_release, buf_full;
    logic [31:0]       buf_wdata, buf_mask;
    logic [AW:0]       buf_used;

    logic [LEN_W-1:0]  len_mem [HDR_DEPTH];
    logic [HAW:0]      len_wr_q, len_rd_q;
    logic              len_push, len_pop, len_empty, len_full;
    logic [LEN_W-1:0]  len_head;

    assign access           = psel && penable && !pready_q;
    assign is_free          = (paddr[11:2] == TX_FREE);
    assign is_commit        = (paddr[11:2] == TX_COMMIT);
    assign unused_addr_bits = ^paddr[1:0];
    assign commit_len       = pwdata[LEN_W-1:0];
    assign free_words       = 32'(DEPTH) - 32'(buf_used);
    assign free_sat         = (free_words > 32'h0000_FFFF) ? 16'hFFFF : free_words[15:0];

    assign len_empty = (len_wr_q == len_rd_q);
    assign len_full  = (len_wr_q[HAW-1:0] == len_rd_q[HAW-1:0]) && (len_wr_q[HAW] != len_rd_q[HAW]);
    assign len_head  = len_mem[len_rd_q[HAW-1:0]];

`ifdef MGMT_TX_FRAME_COUNTER_EN
    logic [15:0] count_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (!link_up) begin
            count_q <= '0;
        end else if (len_pop) begin
            count_q <= count_q + 16'd1;
        end
    end
    assign is_count    = (paddr[11:2] == TX_COUNT);
    assign count_value = count_q;
`else
    assign is_count    = 1'b0;
    assign count_value = '0;
`endif

    // A commit counts the still-staged halfword as one more pushed word.
    assign reject = (commit_len == '0) || (32'(commit_len) > MAX_LEN)
                 || (32'(len_to_words(commit_len)) != 32'(words_q) + 32'(staged_q))
                 || poison_q || len_full || (staged_q && buf_full);

    always_comb begin
        pready_d     = access;
        prdata_d     = '0;
        pslverr_d    = 1'b0;
        staged_d     = staged_q;
        stage_hi_d   = stage_hi_q;
        poison_d     = poison_q;
        words_d      = words_q;
        buf_wr       = 1'b0;
        buf_wdata    = {stage_hi_q, pwdata[7:0], pwdata[15:8]};
        buf_commit   = 1'b0;
        buf_rollback = 1'b0;
        len_push     = 1'b0;
        if (access && !pwrite) begin
            if (is_free) begin
                prdata_d = free_sat;
            end else if (is_count) begin
                prdata_d = count_value;
            end else begin
                pslverr_d = 1'b1;
            end
        end else if (access && link_up) begin
            if (is_free || is_count) begin
                pslverr_d = 1'b1;
            end else if (is_commit) begin
                if (reject) begin
                    pslverr_d    = 1'b1;
                    buf_rollback = 1'b1;
                end else begin
                    buf_wr     = staged_q;
                    buf_wdata  = {stage_hi_q, 16'h0000};
                    buf_commit = 1'b1;
                    len_push   = 1'b1;
                end
                staged_d = 1'b0;
                words_d  = '0;
                poison_d = 1'b0;
            end else if (buf_full) begin
                pslverr_d = 1'b1;
                poison_d  = 1'b1;
            end else if (!staged_q) begin
                stage_hi_d = {pwdata[7:0], pwdata[15:8]};
                staged_d   = 1'b1;
            end else begin
                buf_wr   = 1'b1;
                staged_d = 1'b0;
                words_d  = words_q + 1'b1;
            end
        end
        if (!link_up) begin
            staged_d = 1'b0;
            poison_d = 1'b0;
            words_d  = '0;
        end
    end

    assign issue_bytes = (state_q == S_START) ? len_head : rem_q;
    assign issue_bv    = (issue_bytes >= LEN_W'(4)) ? 3'd4 : issue_bytes[2:0];
    assign issue_rem   = (issue_bytes >= LEN_W'(4)) ? issue_bytes - LEN_W'(4) : '0;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        buf_rd      = 1'b0;
        buf_mask    = byte_mask(issue_bv);
        buf_release = 1'b0;
        len_pop     = 1'b0;
        tx_start_d  = 1'b0;
        tx_dv_d     = 1'b0;
        tx_bv_d     = '0;
        case (state_q)
            S_IDLE: begin
                if (!len_empty && tx_ready && link_up) begin
                    state_d    = S_START;
                    tx_start_d = 1'b1;
                end
            end
            S_START, S_SEND: begin
                if (state_q == S_START || rem_q != '0) begin
                    buf_rd  = 1'b1;
                    tx_dv_d = 1'b1;
                    tx_bv_d = issue_bv;
                    rem_d   = issue_rem;
                    state_d = S_SEND;
                end else begin
                    len_pop     = 1'b1;
                    buf_release = 1'b1;
                    state_d     = S_GAP;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!link_up) begin
            state_d     = S_IDLE;
            buf_rd      = 1'b0;
            buf_release = 1'b0;
            len_pop     = 1'b0;
            tx_start_d  = 1'b0;
            tx_dv_d     = 1'b0;
            tx_bv_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            staged_q   <= 1'b0;
            stage_hi_q <= '0;
            poison_q   <= 1'b0;
            words_q    <= '0;
            state_q    <= S_IDLE;
            rem_q      <= '0;
            tx_start_q <= 1'b0;
            tx_dv_q    <= 1'b0;
            tx_bv_q    <= '0;
            len_wr_q   <= '0;
            len_rd_q   <= '0;
        end else begin
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
            staged_q   <= staged_d;
            stage_hi_q <= stage_hi_d;
            poison_q   <= poison_d;
            words_q    <= words_d;
            state_q    <= state_d;
            rem_q      <= rem_d;
            tx_start_q <= tx_start_d;
            tx_dv_q    <= tx_dv_d;
            tx_bv_q    <= tx_bv_d;
            len_wr_q   <= link_up ? len_wr_q + (HAW+1)'(len_push) : '0;
            len_rd_q   <= link_up ? len_rd_q + (HAW+1)'(len_pop) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (len_push) begin
            len_mem[len_wr_q[HAW-1:0]] <= commit_len;
        end
    end

    tx_packet_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (!link_up),
        .wr_en_i    (buf_wr),
        .wr_data_i  (buf_wdata),
        .commit_i   (buf_commit),
        .rollback_i (buf_rollback),
        .rd_en_i    (buf_rd),
        .rd_mask_i  (buf_mask),
        .release_i  (buf_release),
        .rd_data_o  (tx_data),
        .used_o     (buf_used),
        .full_o     (buf_full)
    );

    assign pready           = pready_q;
    assign prdata           = prdata_q;
    assign pslverr          = pslverr_q;
    assign tx_start         = tx_start_q;
    assign tx_data_valid    = tx_dv_q;
    assign tx_bytes_valid   = tx_bv_q;
    assign tx_frame_pending = !len_empty;

endmodule

// File: tb/tb_management_tx_fifo.sv
// Scoreboard bench for management_tx_fifo: expected tx words are queued at commit
// and popped by a negedge monitor as the DUT replays frames.
module tb_management_tx_fifo;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [15:0] pwdata;
    logic        pready, pslverr;
    logic [15:0] prdata;
    logic        link_up, tx_ready;
    logic        tx_start, tx_data_valid, tx_frame_pending;
    logic [2:0]  tx_bytes_valid;
    logic [31:0] tx_data;

    always #5 clk = ~clk;

    management_tx_fifo #(.DEPTH(DEPTH), .HDR_DEPTH(32), .MAX_LEN(1514)) dut (
        .clk              (clk),
        .reset            (reset),
        .psel             (psel),
        .penable          (penable),
        .pwrite           (pwrite),
        .paddr            (paddr),
        .pwdata           (pwdata),
        .pready           (pready),
        .prdata           (prdata),
        .pslverr          (pslverr),
        .link_up          (link_up),
        .tx_ready         (tx_ready),
        .tx_start         (tx_start),
        .tx_data_valid    (tx_data_valid),
        .tx_bytes_valid   (tx_bytes_valid),
        .tx_data          (tx_data),
        .tx_frame_pending (tx_frame_pending)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_starts = 0;
    logic [34:0] exp_q[$];
    logic        prev_valid = 1'b0;
    logic        prev_start = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        logic [34:0] e;
        if (tx_start) begin
            n_starts++;
            $display("tx: frame start #%0d", n_starts);
            check("gap_before_start", {31'b0, prev_valid}, 32'd0);
        end
        if (prev_start) check("valid_after_start", {31'b0, tx_data_valid}, 32'd1);
        if (tx_data_valid) begin
            check("word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("tx_data", tx_data, e[31:0]);
                check("tx_bytes_valid", {29'b0, tx_bytes_valid}, {29'b0, e[34:32]});
            end
        end
        prev_valid = tx_data_valid;
        prev_start = tx_start;
    end

    task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [15:0] data,
                            output logic [15:0] rdata, output logic err);
        int waits;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        do begin
            @(posedge clk); #1;
            waits++;
        end while (!pready && waits < 8);
        check("apb_wait_states", waits, 32'd1);
        rdata = prdata;
        err = pslverr;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_write(input logic [11:0] addr, input logic [15:0] data, output logic err);
        logic [15:0] unused_rd;
        apb_xfer(1'b1, addr, data, unused_rd, err);
    endtask

    task automatic apb_read(input logic [11:0] addr, output logic [15:0] data, output logic err);
        apb_xfer(1'b0, addr, 16'h0000, data, err);
    endtask

    task automatic read_free(input string tag, input int expv);
        logic [15:0] d;
        logic        e;
        apb_read(12'hFFC, d, e);
        check({tag, "_err"}, {31'b0, e}, 32'd0);
        check(tag, {16'b0, d}, 32'(expv));
    endtask

    task automatic write_halfwords(input int nhw, input logic [7:0] seed, output int errs);
        logic err;
        errs = 0;
        for (int i = 0; i < nhw; i++) begin
            apb_write(12'((2 * i) % 12'hF00), {8'(seed + 2 * i + 1), 8'(seed + 2 * i)}, err);
            if (err) errs++;
        end
    endtask

    task automatic commit_frame(input int len, input logic [7:0] seed, input logic exp_ok);
        logic        err;
        logic [31:0] w;
        int          nb;
        apb_write(12'hFF8, 16'(len), err);
        $display("apb: commit len=%0d pslverr=%0b", len, err);
        check("commit_pslverr", {31'b0, err}, {31'b0, !exp_ok});
        if (exp_ok) begin
            for (int k = 0; k < (len + 3) / 4; k++) begin
                for (int j = 0; j < 4; j++) begin
                    w[31 - 8 * j -: 8] = (4 * k + j < len) ? 8'(seed + 4 * k + j) : 8'h00;
                end
                nb = (len - 4 * k > 4) ? 4 : len - 4 * k;
                exp_q.push_back({3'(nb), w});
            end
        end
    endtask

    task automatic frame(input int nhw, input logic [7:0] seed, input int len, input logic exp_ok);
        int errs;
        write_halfwords(nhw, seed, errs);
        check("data_write_errs", errs, 32'd0);
        commit_frame(len, seed, exp_ok);
    endtask

    task automatic wait_drain(input string tag);
        int cyc = 0;
        while ((exp_q.size() != 0 || tx_data_valid) && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check(tag, exp_q.size(), 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic        e;
        int          errs;
        int          cyc;

        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; link_up = 1'b1; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_pready", {31'b0, pready}, 32'd0);
        check("rst_pslverr", {31'b0, pslverr}, 32'd0);
        check("rst_prdata", {16'b0, prdata}, 32'd0);
        check("rst_tx_start", {31'b0, tx_start}, 32'd0);
        check("rst_tx_valid", {31'b0, tx_data_valid}, 32'd0);
        check("rst_tx_bytes", {29'b0, tx_bytes_valid}, 32'd0);
        check("rst_tx_data", tx_data, 32'd0);
        check("rst_pending", {31'b0, tx_frame_pending}, 32'd0);
        read_free("free_after_reset", DEPTH);

        apb_read(12'h010, d, e);
        check("rd_wo_err", {31'b0, e}, 32'd1);
        check("rd_wo_data", {16'b0, d}, 32'd0);
        apb_write(12'hFFC, 16'h1234, e);
        check("wr_ro_err", {31'b0, e}, 32'd1);

        // 60-byte frame, held back until tx_ready
        frame(30, 8'h00, 60, 1'b1);
        check("pending_a", {31'b0, tx_frame_pending}, 32'd1);
        read_free("free_a", DEPTH - 15);
        check("no_start_without_ready", n_starts, 32'd0);
        tx_ready = 1'b1;
        wait_drain("drain_a");
        check("starts_a", n_starts, 32'd1);
        check("pending_a_done", {31'b0, tx_frame_pending}, 32'd0);

        // 61-byte frame: commit flushes the staged halfword, last lane only
        frame(31, 8'h00, 61, 1'b1);
        wait_drain("drain_b");
        check("starts_b", n_starts, 32'd2);
        read_free("free_b", DEPTH);

        // rejected commits
        frame(4, 8'h10, 1515, 1'b0);
        read_free("free_rej_maxlen", DEPTH);
        frame(4, 8'h10, 12, 1'b0);
        read_free("free_rej_mismatch", DEPTH);
        frame(2, 8'h10, 0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("starts_after_reject", n_starts, 32'd2);
        check("pending_after_reject", {31'b0, tx_frame_pending}, 32'd0);
        read_free("free_rej_zero", DEPTH);

        // fill the buffer, overflow, then the poisoned commit must fail
        tx_ready = 1'b0;
        write_halfwords(2 * DEPTH, 8'h20, errs);
        check("fill_errs", errs, 32'd0);
        read_free("free_full", 0);
        apb_write(12'h000, 16'hBEEF, e);
        check("overflow_err", {31'b0, e}, 32'd1);
        commit_frame(8, 8'h00, 1'b0);
        read_free("free_after_poison", DEPTH);
        check("pending_after_poison", {31'b0, tx_frame_pending}, 32'd0);

        // link drop in the middle of a 64-byte frame
        frame(32, 8'h40, 64, 1'b1);
        tx_ready = 1'b1;
        cyc = 0;
        while (!tx_data_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("link_test_started", {31'b0, tx_data_valid}, 32'd1);
        repeat (3) @(posedge clk);
        #1 link_up = 1'b0;
        @(posedge clk); #1;
        check("drop_valid", {31'b0, tx_data_valid}, 32'd0);
        check("drop_data", tx_data, 32'd0);
        check("drop_pending", {31'b0, tx_frame_pending}, 32'd0);
        exp_q.delete();
        read_free("free_link_down", DEPTH);
        apb_write(12'h000, 16'h5555, e);
        check("write_link_down_err", {31'b0, e}, 32'd0);
        link_up = 1'b1;
        read_free("free_link_up", DEPTH);
        check("starts_drop", n_starts, 32'd3);

        // three queued frames back to back
        tx_ready = 1'b0;
        frame(4, 8'h80, 8, 1'b1);
        frame(7, 8'h90, 13, 1'b1);
        frame(10, 8'hA0, 20, 1'b1);
        check("pending_three", {31'b0, tx_frame_pending}, 32'd1);
        tx_ready = 1'b1;
        wait_drain("drain_three");
        check("starts_three", n_starts, 32'd6);
        read_free("free_three", DEPTH);
`ifdef MGMT_TX_FRAME_COUNTER_EN
        apb_read(12'hFF4, d, e);
        check("count_err", {31'b0, e}, 32'd0);
        check("count_value", {16'b0, d}, 32'd3);
`else
        apb_read(12'hFF4, d, e);
        check("count_absent_err", {31'b0, e}, 32'd1);
        check("count_absent_data", {16'b0, d}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
